// File: rtl/unified_mem_ctrl_pkg.sv
// Shared types and elaboration helpers for the unified memory controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DACC   = 2'd1,
        IFETCH = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Number of memory words that make up one instruction.
    function automatic int beats_f(input int instr_width, input int data_width);
        return instr_width / data_width;
    endfunction

    // Beat counter width; a single-beat fetch still gets a 1-bit counter.
    function automatic int cnt_w_f(input int beats);
        return (beats <= 1) ? 1 : $clog2(beats);
    endfunction

endpackage

// File: rtl/unified_mem_ctrl_sram_sp.sv
// Synchronous single-port RAM with registered read data; contents are never reset.
module sram_sp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Read-before-write array access; rdata reflects the old word on a write cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/unified_mem_ctrl.sv
// Unified instruction/data memory controller: arbitrates fetch and data
// requests onto one single-port array, assembles multi-word instructions
// and suppresses writes into the protected code region.
//
// Handshake: a requester raises req with its address/data and holds them
// until it sees a one-cycle ack; it drops req at the clock edge that ends
// the ack cycle. Requests are only sampled in IDLE, data before fetch.
module unified_mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 10,
    parameter int INSTR_WIDTH = 16,
    parameter int PROT_EN     = 1,
    parameter int PROT_LO     = 32,
    parameter int PROT_HI     = 63
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_req,
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    output logic                   i_ack,
    output logic [INSTR_WIDTH-1:0] i_data,
    input  logic                   d_req,
    input  logic                   d_we,
    input  logic [ADDR_WIDTH-1:0]  d_addr,
    input  logic [DATA_WIDTH-1:0]  d_wdata,
    output logic                   d_ack,
    output logic [DATA_WIDTH-1:0]  d_rdata,
    output logic                   prot_err,
    output logic                   busy,
    output state_t                 dbg_state
);

    localparam int BEATS = beats_f(INSTR_WIDTH, DATA_WIDTH);
    localparam int CW    = cnt_w_f(BEATS);
    localparam logic [CW-1:0]         LAST_BEAT = CW'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] PROT_LO_A = ADDR_WIDTH'(PROT_LO);
    localparam logic [ADDR_WIDTH-1:0] PROT_HI_A = ADDR_WIDTH'(PROT_HI);

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   we_q, we_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   perr_q, perr_d;
    logic                   is_fetch_q, is_fetch_d;
    logic [CW-1:0]          beat_q, beat_d;
    logic [INSTR_WIDTH-1:0] asm_q, asm_d;
    logic [INSTR_WIDTH-1:0] i_data_q, i_data_d;
    logic [DATA_WIDTH-1:0]  d_rdata_q, d_rdata_d;

    logic                   prot_hit;
    logic                   mem_we;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0]  mem_rdata;

    sram_sp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sram (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    // Protected-range compare on the incoming data address.
    always_comb begin
        prot_hit = (PROT_EN != 0) && (d_addr >= PROT_LO_A) && (d_addr <= PROT_HI_A);
    end

    // State and datapath registers; array contents are deliberately outside reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            perr_q     <= 1'b0;
            is_fetch_q <= 1'b0;
            beat_q     <= '0;
            asm_q      <= '0;
            i_data_q   <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            perr_q     <= perr_d;
            is_fetch_q <= is_fetch_d;
            beat_q     <= beat_d;
            asm_q      <= asm_d;
            i_data_q   <= i_data_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Next-state logic: data wins arbitration, fetch runs one cycle per beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (d_req) begin
                    state_d = DACC;
                end else if (i_req) begin
                    state_d = IFETCH;
                end
            end
            DACC:   state_d = DONE;
            IFETCH: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latching, beat counting and instruction assembly.
    always_comb begin
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        perr_d     = perr_q;
        is_fetch_d = is_fetch_q;
        beat_d     = beat_q;
        asm_d      = asm_q;
        i_data_d   = i_data_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (d_req) begin
                    addr_d     = d_addr;
                    we_d       = d_we;
                    wdata_d    = d_wdata;
                    perr_d     = d_we && prot_hit;
                    is_fetch_d = 1'b0;
                end else if (i_req) begin
                    addr_d     = i_addr;
                    we_d       = 1'b0;
                    perr_d     = 1'b0;
                    is_fetch_d = 1'b1;
                    beat_d     = '0;
                end
            end
            IFETCH: begin
                if (beat_q != LAST_BEAT) begin
                    beat_d = beat_q + 1'b1;
                end
                // The word read in beat k-1 arrives while beat k is issuing.
                for (int s = 0; s < BEATS - 1; s++) begin
                    if (beat_q == CW'(s + 1)) begin
                        asm_d[s*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
                    end
                end
            end
            DONE: begin
                if (is_fetch_q) begin
                    asm_d[(BEATS-1)*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
                    i_data_d = asm_d;
                end else if (!we_q) begin
                    d_rdata_d = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    // Outputs and array controls decoded from the current state.
    always_comb begin
        busy      = (state_q != IDLE);
        i_ack     = (state_q == DONE) && is_fetch_q;
        d_ack     = (state_q == DONE) && !is_fetch_q;
        prot_err  = d_ack && perr_q;
        i_data    = i_ack ? i_data_d : i_data_q;
        d_rdata   = (d_ack && !we_q) ? mem_rdata : d_rdata_q;
        mem_we    = (state_q == DACC) && we_q && !perr_q;
        mem_addr  = (state_q == IFETCH) ? (addr_q + ADDR_WIDTH'(beat_q)) : addr_q;
        dbg_state = state_q;
    end

endmodule
